// File: rtl/bin2bcd_seq_n_bits_if.sv
// Start/busy/done handshake and BCD result bundle for bin2bcd_seq_n_bits.
// The optional blank vector is present only when BCD_LEADING_BLANK_EN is defined.
interface bin2bcd_seq_n_bits_if #(
  parameter int unsigned N      = 16,
  parameter int unsigned DIGITS = 5
);
  logic                  start;
  logic [N-1:0]          bin;
  logic                  busy;
  logic                  done;
  logic [4*DIGITS-1:0]   bcd;
  logic                  ovf;
`ifdef BCD_LEADING_BLANK_EN
  logic [DIGITS-1:0]     blank;

  modport master (output start, bin, input busy, done, bcd, ovf, blank);
  modport slave  (input start, bin, output busy, done, bcd, ovf, blank);
`else
  modport master (output start, bin, input busy, done, bcd, ovf);
  modport slave  (input start, bin, output busy, done, bcd, ovf);
`endif
endinterface

// File: rtl/bin2bcd_seq_n_bits.sv
// Sequential double-dabble binary-to-BCD converter, one input bit per clock.
// Optional macro BCD_LEADING_BLANK_EN adds a registered leading-zero blank vector.
module bin2bcd_seq_n_bits #(
  parameter int unsigned N      = 16,
  parameter int unsigned DIGITS = 5
) (
  input  logic                   clk,
  input  logic                   aclr,
  bin2bcd_seq_n_bits_if.slave    bus
);

  localparam int unsigned BW = 4 * DIGITS;
  localparam int unsigned CW = $clog2(N + 1);

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_SHIFT = 1'b1;

  logic [0:0]    state_q, state_d;
  logic [N-1:0]  bin_q,   bin_d;
  logic [BW-1:0] work_q,  work_d;
  logic          ovfw_q,  ovfw_d;
  logic [CW-1:0] cnt_q,   cnt_d;
  logic          busy_q,  busy_d;
  logic          done_q,  done_d;
  logic [BW-1:0] bcd_q,   bcd_d;
  logic          ovf_q,   ovf_d;
  logic [BW-1:0] adj_c;

`ifdef BCD_LEADING_BLANK_EN
  localparam logic [DIGITS-1:0] BLANK_RST = ~(DIGITS'(1));
  logic [DIGITS-1:0] blank_q, blank_d;
`endif

  // Add-3 correction on every working digit that would overflow when doubled
  always_comb begin
    adj_c = work_q;
    for (int k = 0; k < int'(DIGITS); k++) begin
      if (work_q[4*k +: 4] >= 4'd5) adj_c[4*k +: 4] = work_q[4*k +: 4] + 4'd3;
    end
  end

  always_comb begin
    state_d = state_q;
    bin_d   = bin_q;
    work_d  = work_q;
    ovfw_d  = ovfw_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    bcd_d   = bcd_q;
    ovf_d   = ovf_q;
`ifdef BCD_LEADING_BLANK_EN
    blank_d = blank_q;
`endif
    case (state_q)
      S_IDLE: begin
        busy_d = 1'b0;
        if (bus.start) begin
          bin_d   = bus.bin;
          work_d  = '0;
          ovfw_d  = 1'b0;
          cnt_d   = CW'(N);
          busy_d  = 1'b1;
          state_d = S_SHIFT;
        end
      end
      S_SHIFT: begin
        work_d = {adj_c[BW-2:0], bin_q[N-1]};
        bin_d  = {bin_q[N-2:0], 1'b0};
        ovfw_d = ovfw_q | adj_c[BW-1];
        cnt_d  = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          bcd_d   = work_d;
          ovf_d   = ovfw_d;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = S_IDLE;
`ifdef BCD_LEADING_BLANK_EN
          // Scan from the top digit down; digit 0 always stays lit
          begin
            logic hi_zero;
            hi_zero = 1'b1;
            for (int k = int'(DIGITS) - 1; k >= 1; k--) begin
              hi_zero    = hi_zero && (work_d[4*k +: 4] == 4'd0);
              blank_d[k] = hi_zero;
            end
            blank_d[0] = 1'b0;
          end
`endif
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge aclr) begin
    if (!aclr) begin
      state_q <= S_IDLE;
      bin_q   <= '0;
      work_q  <= '0;
      ovfw_q  <= 1'b0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      bcd_q   <= '0;
      ovf_q   <= 1'b0;
`ifdef BCD_LEADING_BLANK_EN
      blank_q <= BLANK_RST;
`endif
    end else begin
      state_q <= state_d;
      bin_q   <= bin_d;
      work_q  <= work_d;
      ovfw_q  <= ovfw_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      bcd_q   <= bcd_d;
      ovf_q   <= ovf_d;
`ifdef BCD_LEADING_BLANK_EN
      blank_q <= blank_d;
`endif
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.bcd  = bcd_q;
  assign bus.ovf  = ovf_q;
`ifdef BCD_LEADING_BLANK_EN
  assign bus.blank = blank_q;
`endif

endmodule

// File: tb/tb_bin2bcd_seq_n_bits.sv
// Directed scoreboard bench for bin2bcd_seq_n_bits: a 5-digit and a 3-digit instance.
module tb_bin2bcd_seq_n_bits;

  localparam int unsigned N  = 16;
  localparam int unsigned DA = 5;
  localparam int unsigned DB = 3;

  logic clk = 1'b0;
  logic aclr;
  always #5 clk = ~clk;

  bin2bcd_seq_n_bits_if #(.N(N), .DIGITS(DA)) ifa ();
  bin2bcd_seq_n_bits_if #(.N(N), .DIGITS(DB)) ifb ();

  bin2bcd_seq_n_bits #(.N(N), .DIGITS(DA)) dut_a (.clk(clk), .aclr(aclr), .bus(ifa.slave));
  bin2bcd_seq_n_bits #(.N(N), .DIGITS(DB)) dut_b (.clk(clk), .aclr(aclr), .bus(ifb.slave));

  typedef struct packed {
    logic [19:0] bcd;
    logic        ovf;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  int   tests = 0;
  int   fails = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected blank vector derived from an expected BCD value with d digits
  function automatic logic [4:0] blank_model(input logic [19:0] b, input int d);
    logic [4:0] r;
    logic       z;
    r = '0;
    z = 1'b1;
    for (int k = d - 1; k >= 1; k--) begin
      z    = z && (b[4*k +: 4] == 4'd0);
      r[k] = z;
    end
    return r;
  endfunction

  task automatic drive_a(input logic [15:0] v, input logic [19:0] eb, input logic eo, input bit push);
    ifa.bin   = v;
    ifa.start = 1'b1;
    if (push) qa.push_back('{bcd: eb, ovf: eo});
    @(negedge clk);
    ifa.start = 1'b0;
  endtask

  task automatic wait_a(input string tag, input int exp_busy);
    int          cyc;
    bit          seen;
    bit          held;
    logic [19:0] b0;
    logic        o0;
    exp_t        e;
    cyc  = 0;
    seen = 1'b0;
    held = 1'b1;
    b0   = ifa.bcd;
    o0   = ifa.ovf;
    for (int i = 0; i < 40; i++) begin
      if (ifa.done === 1'b1) begin
        seen = 1'b1;
        break;
      end
      if (ifa.busy === 1'b1) cyc++;
      if (ifa.bcd !== b0 || ifa.ovf !== o0) held = 1'b0;
      @(negedge clk);
    end
    chk({tag, "_done_seen"}, 32'(seen), 32'd1);
    chk({tag, "_busy_cycles"}, 32'(cyc), 32'(exp_busy));
    chk({tag, "_held_in_shift"}, 32'(held), 32'd1);
    chk({tag, "_busy_at_done"}, 32'(ifa.busy), 32'd0);
    chk({tag, "_sb_nonempty"}, 32'(qa.size() != 0), 32'd1);
    if (qa.size() != 0) begin
      e = qa.pop_front();
      chk({tag, "_bcd"}, 32'(ifa.bcd), 32'(e.bcd));
      chk({tag, "_ovf"}, 32'(ifa.ovf), 32'(e.ovf));
`ifdef BCD_LEADING_BLANK_EN
      chk({tag, "_blank"}, 32'(ifa.blank), 32'(blank_model(e.bcd, DA)));
`endif
    end
  endtask

  task automatic run_b(input string tag, input logic [15:0] v, input logic [11:0] eb, input logic eo);
    bit   seen;
    exp_t e;
    seen      = 1'b0;
    ifb.bin   = v;
    ifb.start = 1'b1;
    qb.push_back('{bcd: 20'(eb), ovf: eo});
    @(negedge clk);
    ifb.start = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (ifb.done === 1'b1) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk({tag, "_done_seen"}, 32'(seen), 32'd1);
    chk({tag, "_sb_nonempty"}, 32'(qb.size() != 0), 32'd1);
    if (qb.size() != 0) begin
      e = qb.pop_front();
      chk({tag, "_bcd"}, 32'(ifb.bcd), 32'(e.bcd));
      chk({tag, "_ovf"}, 32'(ifb.ovf), 32'(e.ovf));
`ifdef BCD_LEADING_BLANK_EN
      chk({tag, "_blank"}, 32'(ifb.blank), 32'(blank_model(e.bcd, DB)));
`endif
    end
    @(negedge clk);
  endtask

  initial begin
    bit saw_done;
    aclr      = 1'b0;
    ifa.start = 1'b0;
    ifa.bin   = '0;
    ifb.start = 1'b0;
    ifb.bin   = '0;
    #12;
    chk("rst_busy", 32'(ifa.busy), 32'd0);
    chk("rst_done", 32'(ifa.done), 32'd0);
    chk("rst_bcd",  32'(ifa.bcd),  32'd0);
    chk("rst_ovf",  32'(ifa.ovf),  32'd0);
`ifdef BCD_LEADING_BLANK_EN
    chk("rst_blank", 32'(ifa.blank), 32'h1e);
`endif
    @(negedge clk);
    aclr = 1'b1;
    @(negedge clk);

    drive_a(16'd0, 20'h00000, 1'b0, 1'b1);
    wait_a("zero", 16);
    @(negedge clk);
    chk("zero_done_pulse", 32'(ifa.done), 32'd0);

    drive_a(16'd12345, 20'h12345, 1'b0, 1'b1);
    wait_a("d12345", 16);
    @(negedge clk);
    chk("d12345_done_pulse", 32'(ifa.done), 32'd0);

    // Back-to-back: restart in the done cycle, no idle gap expected
    drive_a(16'd65535, 20'h65535, 1'b0, 1'b1);
    wait_a("d65535", 16);
    drive_a(16'd255, 20'h00255, 1'b0, 1'b1);
    chk("b2b_done_clr", 32'(ifa.done), 32'd0);
    chk("b2b_busy_nogap", 32'(ifa.busy), 32'd1);
    wait_a("d255", 16);
    @(negedge clk);

    // Start pulse and bin change mid-conversion must be ignored
    drive_a(16'd9999, 20'h09999, 1'b0, 1'b1);
    repeat (4) @(negedge clk);
    ifa.start = 1'b1;
    ifa.bin   = 16'd1;
    @(negedge clk);
    ifa.start = 1'b0;
    wait_a("d9999", int'(N) - 5);
    @(negedge clk);

    // Asynchronous abort at cycle 8
    drive_a(16'd777, 20'h00777, 1'b0, 1'b0);
    repeat (7) @(negedge clk);
    aclr = 1'b0;
    #1;
    chk("abort_busy", 32'(ifa.busy), 32'd0);
    chk("abort_done", 32'(ifa.done), 32'd0);
    chk("abort_bcd",  32'(ifa.bcd),  32'd0);
    chk("abort_ovf",  32'(ifa.ovf),  32'd0);
`ifdef BCD_LEADING_BLANK_EN
    chk("abort_blank", 32'(ifa.blank), 32'h1e);
`endif
    @(negedge clk);
    aclr = 1'b1;
    saw_done = 1'b0;
    for (int i = 0; i < 24; i++) begin
      if (ifa.done !== 1'b0) saw_done = 1'b1;
      @(negedge clk);
    end
    chk("abort_no_done", 32'(saw_done), 32'd0);
    chk("abort_idle_busy", 32'(ifa.busy), 32'd0);

    drive_a(16'd42, 20'h00042, 1'b0, 1'b1);
    wait_a("d42", 16);
    @(negedge clk);

    // Three-digit instance: overflow keeps the low digits
    run_b("b1234", 16'd1234, 12'h234, 1'b1);
    run_b("b999",  16'd999,  12'h999, 1'b0);

    chk("sb_a_drained", 32'(qa.size()), 32'd0);
    chk("sb_b_drained", 32'(qb.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
